// File: rtl/tone_synth.sv
// tone_synth: multi-channel square-wave tone generator.
// Note codes arrive on a valid/ready write port. A small FSM derives the
// half-period as BASE[semitone] >> octave by repeated subtraction of 12
// (one step per clock). The result is staged per channel and only takes
// effect at a waveform edge, so the outputs never produce runt pulses.
// Optional feature macro: TONE_TRANSPOSE_EN adds the trans_up input, an
// extra octave-up shift that is sampled when a write is accepted.
`timescale 1ns/1ps
module tone_synth #(
  parameter int CHANNELS = 2,
  parameter int NOTE_W   = 8,
  parameter int CNT_W    = 17,
  parameter int MAX_NOTE = 36,
  localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [CH_W-1:0]     wr_ch,
  input  logic [NOTE_W-1:0]   wr_note,
`ifdef TONE_TRANSPOSE_EN
  input  logic [1:0]          trans_up,
`endif
  output logic [CHANNELS-1:0] tone,
  output logic [CHANNELS-1:0] active
);

  localparam int SH_W = (CNT_W > 17) ? CNT_W : 17;

  typedef enum logic [1:0] {S_IDLE, S_DECODE, S_APPLY} state_e;

  state_e             state_q;
  logic               rdy_q;
  logic [CH_W-1:0]    ch_q;
  logic [NOTE_W-1:0]  rem_q;
  logic [NOTE_W-1:0]  oct_q;
  logic [1:0]         trans_q;
  logic [CNT_W-1:0]   dec_period_q;
  logic [1:0]         trans_in;
  logic [NOTE_W:0]    shamt;
  logic [SH_W-1:0]    shifted;
  logic [CNT_W-1:0]   dec_period;

`ifdef TONE_TRANSPOSE_EN
  assign trans_in = trans_up;
`else
  assign trans_in = 2'd0;
`endif

  // Lowest-octave half-period for each semitone (C .. B).
  function automatic logic [16:0] base_lut(input logic [3:0] s);
    case (s)
      4'd0:    base_lut = 17'd95556;
      4'd1:    base_lut = 17'd90193;
      4'd2:    base_lut = 17'd85131;
      4'd3:    base_lut = 17'd80353;
      4'd4:    base_lut = 17'd75843;
      4'd5:    base_lut = 17'd71586;
      4'd6:    base_lut = 17'd67568;
      4'd7:    base_lut = 17'd63776;
      4'd8:    base_lut = 17'd60196;
      4'd9:    base_lut = 17'd56818;
      4'd10:   base_lut = 17'd53629;
      4'd11:   base_lut = 17'd50619;
      default: base_lut = 17'd0;
    endcase
  endfunction

  // Period for the current decode state: the shift drops LSBs, and a zero
  // result naturally reads as silence downstream.
  always_comb begin
    // NOTE: every always_comb output gets an unconditional assignment so no latch is inferred.
    shamt      = {1'b0, oct_q} + (NOTE_W+1)'(trans_q);
    shifted    = SH_W'(base_lut(rem_q[3:0])) >> shamt;
    dec_period = CNT_W'(shifted);
  end

  // Ready is a registered flag, additionally masked while reset is held.
  assign wr_ready = rdy_q & ~rst;

  // Write-port FSM: accept, decode semitone/octave, hand off to a channel.
  always_ff @(posedge clk) begin
    // NOTE: synchronous reset inside the clocked block; all state uses non-blocking (<=) assignments.
    if (rst) begin
      state_q      <= S_IDLE;
      rdy_q        <= 1'b1;
      ch_q         <= '0;
      rem_q        <= '0;
      oct_q        <= '0;
      trans_q      <= '0;
      dec_period_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (wr_valid && rdy_q) begin
            ch_q    <= wr_ch;
            trans_q <= trans_in;
            rdy_q   <= 1'b0;
            if ((wr_note != '0) && (wr_note <= NOTE_W'(MAX_NOTE))) begin
              rem_q   <= wr_note - NOTE_W'(1);
              oct_q   <= '0;
              state_q <= S_DECODE;
            end else begin
              dec_period_q <= '0;
              state_q      <= S_APPLY;
            end
          end
        end
        S_DECODE: begin
          if (rem_q >= NOTE_W'(12)) begin
            rem_q <= rem_q - NOTE_W'(12);
            oct_q <= oct_q + NOTE_W'(1);
          end else begin
            dec_period_q <= dec_period;
            state_q      <= S_APPLY;
          end
        end
        S_APPLY: begin
          state_q <= S_IDLE;
          rdy_q   <= 1'b1;
        end
        default: begin
          state_q <= S_IDLE;
          rdy_q   <= 1'b1;
        end
      endcase
    end
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [CNT_W-1:0] period_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] pend_q;
    logic             pend_vld_q;
    logic             tone_q;
    logic             apply_hit;
    logic             wrap;
    logic             consume;

    // Out-of-range channel numbers match no generate instance and are dropped.
    assign apply_hit = (state_q == S_APPLY) && (ch_q == CH_W'(c));
    assign wrap      = (cnt_q == period_q - CNT_W'(1));
    assign consume   = pend_vld_q && ((period_q == '0) || wrap);

    // Per-channel counter/toggle; a staged period is adopted only when idle or at an edge.
    always_ff @(posedge clk) begin
      if (rst) begin
        period_q   <= '0;
        cnt_q      <= '0;
        pend_q     <= '0;
        pend_vld_q <= 1'b0;
        tone_q     <= 1'b0;
      end else begin
        if (apply_hit) begin
          pend_q <= dec_period_q;
        end
        // A write landing in the same cycle as a consume must survive.
        pend_vld_q <= apply_hit | (pend_vld_q & ~consume);

        if (period_q == '0) begin
          cnt_q <= '0;
          if (pend_vld_q) begin
            period_q <= pend_q;
            tone_q   <= 1'b0;
          end
        end else if (wrap) begin
          cnt_q <= '0;
          if (pend_vld_q) begin
            period_q <= pend_q;
            tone_q   <= (pend_q == '0) ? 1'b0 : ~tone_q;
          end else begin
            tone_q <= ~tone_q;
          end
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
    end

    assign tone[c]   = tone_q;
    assign active[c] = (period_q != '0);
  end

endmodule

// File: tb/tb_tone_synth.sv
// Directed testbench for tone_synth (default two channels).
// Outputs are sampled on the falling clock edge; a background monitor
// stamps every tone transition with its cycle number so half-periods can be
// compared against hand-computed values without long lock-step loops.
`timescale 1ns/1ps
module tb_tone_synth;

  logic       clk      = 1'b0;
  logic       rst      = 1'b1;
  logic       wr_valid = 1'b0;
  logic [0:0] wr_ch    = 1'b0;
  logic [7:0] wr_note  = 8'd0;
  logic       wr_ready;
  logic [1:0] tone;
  logic [1:0] active;
`ifdef TONE_TRANSPOSE_EN
  logic [1:0] trans_up = 2'd0;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int n_edge[2]      = '{0, 0};
  int edge_cyc[2][8] = '{default: 0};
  logic [1:0] tone_prev = 2'b00;

  always #5 clk = ~clk;

  tone_synth dut (
    .clk      (clk),
    .rst      (rst),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_ch    (wr_ch),
    .wr_note  (wr_note),
`ifdef TONE_TRANSPOSE_EN
    .trans_up (trans_up),
`endif
    .tone     (tone),
    .active   (active)
  );

  // Cycle counter and tone-edge logger; cyc = number of rising edges so far.
  always begin
    @(posedge clk);
    #1;
    cyc = cyc + 1;
    for (int c = 0; c < 2; c++) begin
      if (tone[c] !== tone_prev[c]) begin
        if (n_edge[c] < 8) edge_cyc[c][n_edge[c]] = cyc;
        n_edge[c] = n_edge[c] + 1;
      end
    end
    tone_prev = tone;
  end

  initial begin
    #(10 * 100000);
    $display("FAIL watchdog: simulation did not finish, cyc %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // Issue one write; returns the cycle right after the accepting edge (T+1).
  task automatic do_write(input logic ch, input logic [7:0] note, output int acc);
    int waited;
    waited = 0;
    while (wr_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("ready_before_write", {31'd0, wr_ready}, 32'd1);
    wr_valid = 1'b1;
    wr_ch    = ch;
    wr_note  = note;
    @(negedge clk);
    wr_valid = 1'b0;
    acc      = cyc;
  endtask

  initial begin
    int a, l1, l0, l0b;

    // Reset held for three clocks.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready_low", {31'd0, wr_ready}, 32'd0);
    check("rst_tone",      {30'd0, tone},     32'd0);
    check("rst_active",    {30'd0, active},   32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", {31'd0, wr_ready}, 32'd1);

    // Note 1 on ch0: ready low T+1..T+2, high T+3, active at T+4.
    do_write(1'b0, 8'd1, a);
    check("n1_ready_t1", {31'd0, wr_ready}, 32'd0);
    step(1);
    check("n1_ready_t2", {31'd0, wr_ready}, 32'd0);
    step(1);
    check("n1_ready_t3",  {31'd0, wr_ready},  32'd1);
    check("n1_active_t3", {30'd0, active},    32'd0);
    step(1);
    check("n1_active_t4", {30'd0, active},    32'd1);
    check("n1_tone_t4",   {30'd0, tone},      32'd0);

    // Reset during decode of note 36: the write is lost, ch0 is cleared.
    do_write(1'b1, 8'd36, a);
    rst = 1'b1;
    step(1);
    check("mid_rst_ready",  {31'd0, wr_ready}, 32'd0);
    check("mid_rst_active", {30'd0, active},   32'd0);
    check("mid_rst_tone",   {30'd0, tone},     32'd0);
    rst = 1'b0;
    step(1);
    check("mid_rst_ready_after", {31'd0, wr_ready}, 32'd1);
    step(6);
    check("mid_rst_write_lost", {30'd0, active}, 32'd0);

    // Note 25 on ch1: three decode steps, period 95556>>2 = 23889.
    do_write(1'b1, 8'd25, a);
    step(3);
    check("n25_ready_t4",  {31'd0, wr_ready}, 32'd0);
    check("n25_active_t4", {30'd0, active},   32'd0);
    step(1);
    check("n25_ready_t5",  {31'd0, wr_ready}, 32'd1);
    step(1);
    check("n25_active_t6", {30'd0, active},   32'd2);
    l1 = cyc;

    // Note 13 (remainder exactly 12) then note 36 to ch1 before its first wrap: last write wins.
    do_write(1'b1, 8'd13, a);
    step(2);
    check("n13_ready_t3", {31'd0, wr_ready}, 32'd0);
    step(1);
    check("n13_ready_t4", {31'd0, wr_ready}, 32'd1);
    do_write(1'b1, 8'd36, a);
    step(3);
    check("n36_ready_t4", {31'd0, wr_ready}, 32'd0);
    step(1);
    check("n36_ready_t5", {31'd0, wr_ready}, 32'd1);

    // ch0 runs note 36 (12654); note 200 silences it at its first wrap with no rising edge.
    do_write(1'b0, 8'd36, a);
    step(4);
    check("ch0_active_t5", {31'd0, active[0]}, 32'd0);
    step(1);
    check("ch0_active_t6", {31'd0, active[0]}, 32'd1);
    l0 = cyc;
    do_write(1'b0, 8'd200, a);
    check("silence_ready_t1", {31'd0, wr_ready}, 32'd0);
    step(1);
    check("silence_ready_t2", {31'd0, wr_ready}, 32'd1);
    wait_until(l0 + 12653);
    check("n200_pre_active", {31'd0, active[0]}, 32'd1);
    check("n200_pre_tone",   {31'd0, tone[0]},   32'd0);
    step(1);
    check("n200_wrap_active", {31'd0, active[0]}, 32'd0);
    check("n200_wrap_tone",   {31'd0, tone[0]},   32'd0);

    // Restart ch0 on note 36 and silence it with note 0.
    do_write(1'b0, 8'd36, a);
    step(5);
    check("ch0b_active", {31'd0, active[0]}, 32'd1);
    l0b = cyc;
    do_write(1'b0, 8'd0, a);
    wait_until(l0b + 12653);
    check("n0_pre_active", {31'd0, active[0]}, 32'd1);
    step(1);
    check("n0_wrap_active", {31'd0, active[0]}, 32'd0);
    check("n0_wrap_tone",   {31'd0, tone[0]},   32'd0);
    check("ch1_high_phase", {31'd0, tone[1]},   32'd1);

    // ch1: first edge after 23889 clk at old period, next after 12654 clk.
    wait_until(l1 + 36543 + 3);
    check("ch1_edge_count", n_edge[1],      32'd2);
    check("ch1_rise_cycle", edge_cyc[1][0], l1 + 23889);
    check("ch1_fall_cycle", edge_cyc[1][1], l1 + 23889 + 12654);
    check("ch1_tone_low",   {31'd0, tone[1]},   32'd0);
    check("ch1_active",     {31'd0, active[1]}, 32'd1);
    check("ch0_no_edges",   n_edge[0],      32'd0);

    // Note 37 (MAX_NOTE+1) is silence: one-cycle busy, channel stays inactive.
    do_write(1'b0, 8'd37, a);
    check("n37_ready_t1", {31'd0, wr_ready}, 32'd0);
    step(1);
    check("n37_ready_t2", {31'd0, wr_ready}, 32'd1);
    step(3);
    check("n37_inactive", {30'd0, active}, 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
